// File: rtl/alu_op_scheduler_pkg.sv
// Shared definitions for the vALU result sequencer: select width, defaults,
// FSM state encoding and the per-select latency rule.
package alu_op_scheduler_pkg;

    localparam int SEL_W        = 4;
    localparam int DEF_NUM_SEL  = 5;
    localparam int DEF_SLOW_SEL = 2;
    localparam int DEF_SLOW_LAT = 3;
    localparam int CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Cycles the mux needs to settle for a given legal select code.
    function automatic logic [CNT_W-1:0] op_latency(input logic [SEL_W-1:0] op,
                                                    input int slow_sel,
                                                    input int slow_lat);
        logic [SEL_W-1:0] slow_code;
        slow_code = slow_sel[SEL_W-1:0];
        if (op == slow_code) begin
            return slow_lat[CNT_W-1:0];
        end
        return CNT_W'(1);
    endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Bundle of the request, ALU-side and response signals of the scheduler.
//
// Handshakes: every channel is valid/ready. A transfer happens on the rising
// edge where both valid and ready are high; the source holds valid and its
// payload stable until then, and ready may depend combinationally on valid.
interface alu_op_scheduler_if
    import alu_op_scheduler_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [SEL_W-1:0] req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [SEL_W-1:0] req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    // Environment side: requesters, the ALU mux and the response consumer.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );

    // Scheduler side.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_op_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is combinational from the request
// vector; the priority pointer moves away from the winner on accept.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // prio = 0 favours requester 0 when both request, prio = 1 favours 1.
    logic prio;

    // Grant the favoured requester on contention, else whoever is requesting.
    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant = prio ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // After an accept, favour the requester that did not win.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Sequencer for the shared vALU result mux: arbitrates two requesters,
// drives registered select/operands, waits out the op latency and returns
// the captured result over a valid/ready response channel.
module alu_op_scheduler
    import alu_op_scheduler_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_SEL  = DEF_NUM_SEL,
    parameter int SLOW_SEL = DEF_SLOW_SEL,
    parameter int SLOW_LAT = DEF_SLOW_LAT
) (
    input  logic                clk,
    input  logic                reset,
    alu_op_scheduler_if.slave   bus,
    output state_t              fsm_state
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             illegal_q;
    logic             id_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [SEL_W-1:0] alu_sel_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;

    logic [1:0]       grant;
    logic             accept;
    logic             win_id;
    logic [SEL_W-1:0] win_op;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             win_legal;
    logic             cnt_done;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({bus.req1_valid, bus.req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    // Request-side decode: ready only in IDLE, winner payload selection.
    always_comb begin
        accept         = (state == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
        bus.req0_ready = (state == ST_IDLE) && grant[0];
        bus.req1_ready = (state == ST_IDLE) && grant[1];
        win_id         = grant[1];
        win_op         = win_id ? bus.req1_op : bus.req0_op;
        win_a          = win_id ? bus.req1_a  : bus.req0_a;
        win_b          = win_id ? bus.req1_b  : bus.req0_b;
        win_legal      = int'(win_op) < NUM_SEL;
        cnt_done       = (cnt == CNT_W'(1));
    end

    // Next-state logic. An illegal op still spends one EXEC cycle so its
    // error response appears with the same one-cycle timing as a fast op.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)        state_next = ST_EXEC;
            ST_EXEC: if (cnt_done)      state_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: load operands on accept, count down, capture the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            illegal_q  <= 1'b0;
            id_q       <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        id_q      <= win_id;
                        illegal_q <= !win_legal;
                        if (win_legal) begin
                            cnt       <= op_latency(win_op, SLOW_SEL, SLOW_LAT);
                            alu_sel_q <= win_op;
                            alu_a_q   <= win_a;
                            alu_b_q   <= win_b;
                        end else begin
                            cnt <= CNT_W'(1);
                        end
                    end
                end
                ST_EXEC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt_done) begin
                        rsp_data_q <= illegal_q ? '0 : bus.alu_result;
                        rsp_err_q  <= illegal_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output drive.
    always_comb begin
        bus.alu_a     = alu_a_q;
        bus.alu_b     = alu_b_q;
        bus.alu_sel   = alu_sel_q;
        bus.rsp_valid = (state == ST_RESP);
        bus.rsp_id    = id_q;
        bus.rsp_data  = rsp_data_q;
        bus.rsp_err   = rsp_err_q;
        fsm_state     = state;
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler with a behavioural model of
// arbitration, latency and result routing.
module tb_alu_op_scheduler;
    import alu_op_scheduler_pkg::*;

    localparam int W      = 32;
    localparam int NSEL   = 5;
    localparam int SLOW   = 2;
    localparam int SLOW_L = 3;

    logic        clk = 1'b0;
    logic        reset;
    state_t      fsm_state;
    logic        force_en;
    logic [W-1:0] force_val;

    int n_checks = 0;
    int n_pass   = 0;
    int last_win = 1;

    int           obs_win, obs_lat;
    logic         obs_id, obs_err, obs_after_valid;
    logic [W-1:0] obs_data, obs_a, obs_b;
    logic [3:0]   obs_sel;
    bit           sel_moved, busy_ready, rsp_moved;
    state_t       obs_after_state;

    alu_op_scheduler_if #(.WIDTH(W)) bus ();

    alu_op_scheduler #(
        .WIDTH(W), .NUM_SEL(NSEL), .SLOW_SEL(SLOW), .SLOW_LAT(SLOW_L)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_ref(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return a & b;
            4'd4:    return a ^ b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign bus.alu_result = force_en ? force_val : alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b);

    function automatic int exp_win(input bit v0, input bit v1);
        if (v0 && v1) return 1 - last_win;
        return v0 ? 0 : 1;
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
        return (op == 4'(SLOW)) ? SLOW_L : 1;
    endfunction

    function automatic logic [W-1:0] exp_data(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (int'(op) >= NSEL) return '0;
        return alu_ref(op, a, b);
    endfunction

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.rsp_ready  = 1;
    endtask

    // Drives one request phase and records what the DUT did; no checking.
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [3:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [3:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input int stall);
        logic         id0, err0;
        logic [W-1:0] data0;
        bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
        bus.rsp_ready  = (stall == 0);
        obs_win = -1; obs_lat = -1; sel_moved = 0; busy_ready = 0; rsp_moved = 0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (bus.req0_ready || bus.req1_ready) break;
            @(posedge clk); #1;
        end
        if (!(bus.req0_ready || bus.req1_ready)) begin
            idle_inputs();
            return;
        end
        obs_win = (bus.req0_ready && bus.req1_ready) ? 2 : (bus.req1_ready ? 1 : 0);
        @(posedge clk); #1;
        if (obs_win == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
        #1;
        obs_sel = bus.alu_sel; obs_a = bus.alu_a; obs_b = bus.alu_b;
        obs_lat = 0;
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) begin
            if (bus.req0_ready || bus.req1_ready) busy_ready = 1;
            if (bus.alu_sel !== obs_sel) sel_moved = 1;
            @(posedge clk); #1;
            obs_lat++;
        end
        if (!bus.rsp_valid) begin
            obs_lat = -1;
            idle_inputs();
            return;
        end
        obs_id = bus.rsp_id; obs_data = bus.rsp_data; obs_err = bus.rsp_err;
        id0 = obs_id; data0 = obs_data; err0 = obs_err;
        for (int i = 0; i < stall; i++) begin
            if (bus.req0_ready || bus.req1_ready) busy_ready = 1;
            if (bus.alu_sel !== obs_sel) sel_moved = 1;
            if (!bus.rsp_valid || bus.rsp_id !== id0 || bus.rsp_data !== data0 || bus.rsp_err !== err0)
                rsp_moved = 1;
            @(posedge clk); #1;
        end
        if (bus.req0_ready || bus.req1_ready) busy_ready = 1;
        if (bus.alu_sel !== obs_sel) sel_moved = 1;
        if (!bus.rsp_valid || bus.rsp_data !== data0) rsp_moved = 1;
        bus.rsp_ready = 1;
        @(posedge clk); #1;
        obs_after_valid = bus.rsp_valid;
        obs_after_state = fsm_state;
        bus.req0_valid = 0; bus.req1_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        force_en = 0; force_val = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        #1;
        n_checks++; if (fsm_state !== ST_IDLE) $display("FAIL reset_state: got %0d exp %0d", fsm_state, ST_IDLE); else n_pass++;
        n_checks++; if (bus.alu_sel !== 4'd0) $display("FAIL reset_alu_sel: got %0h exp 0", bus.alu_sel); else n_pass++;
        n_checks++; if (bus.alu_a !== '0 || bus.alu_b !== '0) $display("FAIL reset_alu_ab: got %0h/%0h exp 0/0", bus.alu_a, bus.alu_b); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0b exp 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_data !== '0 || bus.rsp_err !== 1'b0 || bus.rsp_id !== 1'b0)
            $display("FAIL reset_rsp_fields: got data=%0h err=%0b id=%0b exp 0/0/0", bus.rsp_data, bus.rsp_err, bus.rsp_id); else n_pass++;
        n_checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
            $display("FAIL reset_ready: got %0b%0b exp 00", bus.req1_ready, bus.req0_ready); else n_pass++;
        last_win = 1;
    endtask

    task automatic test_fast_forced();
        force_en = 1; force_val = 32'h2;
        run_txn(1, 0, 4'd1, 32'd5, 32'd9, 4'd0, 0, 0, 0);
        n_checks++; if (obs_win !== exp_win(1, 0)) $display("FAIL fast_win: got %0d exp %0d", obs_win, exp_win(1, 0)); else n_pass++;
        last_win = exp_win(1, 0);
        n_checks++; if (obs_sel !== 4'd1 || obs_a !== 32'd5 || obs_b !== 32'd9)
            $display("FAIL fast_alu_load: got sel=%0h a=%0h b=%0h exp 1/5/9", obs_sel, obs_a, obs_b); else n_pass++;
        n_checks++; if (obs_lat !== 1) $display("FAIL fast_latency: got %0d exp 1", obs_lat); else n_pass++;
        n_checks++; if (obs_id !== 1'b0 || obs_data !== 32'h2 || obs_err !== 1'b0)
            $display("FAIL fast_rsp: got id=%0b data=%0h err=%0b exp 0/2/0", obs_id, obs_data, obs_err); else n_pass++;
        force_en = 0;
    endtask

    task automatic test_slow();
        logic [W-1:0] a, b;
        a = $urandom; b = $urandom;
        run_txn(0, 1, 4'd0, 0, 0, 4'(SLOW), a, b, 0);
        n_checks++; if (obs_win !== exp_win(0, 1)) $display("FAIL slow_win: got %0d exp %0d", obs_win, exp_win(0, 1)); else n_pass++;
        last_win = exp_win(0, 1);
        n_checks++; if (obs_lat !== SLOW_L) $display("FAIL slow_latency: got %0d exp %0d", obs_lat, SLOW_L); else n_pass++;
        n_checks++; if (sel_moved || obs_sel !== 4'(SLOW)) $display("FAIL slow_sel_stable: got sel=%0h moved=%0b exp %0h/0", obs_sel, sel_moved, SLOW); else n_pass++;
        n_checks++; if (obs_id !== 1'b1 || obs_data !== exp_data(4'(SLOW), a, b))
            $display("FAIL slow_rsp: got id=%0b data=%0h exp 1/%0h", obs_id, obs_data, exp_data(4'(SLOW), a, b)); else n_pass++;
    endtask

    task automatic test_alternate();
        int prev;
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] op0, op1;
            logic [W-1:0] a0, b0, a1, b1;
            int ew;
            op0 = 4'($urandom_range(0, NSEL - 1)); op1 = 4'($urandom_range(0, NSEL - 1));
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            ew = exp_win(1, 1);
            run_txn(1, 1, op0, a0, b0, op1, a1, b1, 0);
            n_checks++; if (obs_win !== ew || obs_win == prev)
                $display("FAIL alt_grant_%0d: got %0d exp %0d (prev %0d)", k, obs_win, ew, prev); else n_pass++;
            n_checks++; if (obs_lat !== exp_lat(ew ? op1 : op0) || obs_data !== (ew ? exp_data(op1, a1, b1) : exp_data(op0, a0, b0)))
                $display("FAIL alt_result_%0d: got lat=%0d data=%0h exp %0d/%0h", k, obs_lat, obs_data,
                         exp_lat(ew ? op1 : op0), ew ? exp_data(op1, a1, b1) : exp_data(op0, a0, b0)); else n_pass++;
            n_checks++; if (busy_ready) $display("FAIL alt_busy_ready_%0d: got 1 exp 0", k); else n_pass++;
            prev = ew;
            last_win = ew;
        end
    endtask

    task automatic test_illegal();
        logic [3:0]   op, prev_sel;
        logic [W-1:0] prev_a;
        op = 4'($urandom_range(NSEL, 15));
        prev_sel = bus.alu_sel; prev_a = bus.alu_a;
        run_txn(1, 0, op, $urandom, $urandom, 4'd0, 0, 0, 0);
        last_win = exp_win(1, 0);
        n_checks++; if (obs_lat !== 1) $display("FAIL illegal_latency: got %0d exp 1", obs_lat); else n_pass++;
        n_checks++; if (obs_err !== 1'b1 || obs_data !== '0 || obs_id !== 1'b0)
            $display("FAIL illegal_rsp: got err=%0b data=%0h id=%0b exp 1/0/0", obs_err, obs_data, obs_id); else n_pass++;
        n_checks++; if (obs_sel !== prev_sel || obs_a !== prev_a || sel_moved)
            $display("FAIL illegal_alu_kept: got sel=%0h a=%0h exp %0h/%0h", obs_sel, obs_a, prev_sel, prev_a); else n_pass++;
    endtask

    task automatic test_stall();
        logic [3:0]   op;
        logic [W-1:0] a, b;
        int ew;
        op = 4'($urandom_range(0, NSEL - 1)); a = $urandom; b = $urandom;
        ew = exp_win(1, 1);
        run_txn(1, 1, op, a, b, op, a, b, 5);
        last_win = ew;
        n_checks++; if (obs_win !== ew) $display("FAIL stall_win: got %0d exp %0d", obs_win, ew); else n_pass++;
        n_checks++; if (rsp_moved || obs_data !== exp_data(op, a, b) || obs_id !== 1'(ew))
            $display("FAIL stall_rsp_held: got moved=%0b data=%0h id=%0b exp 0/%0h/%0d", rsp_moved, obs_data, obs_id, exp_data(op, a, b), ew); else n_pass++;
        n_checks++; if (busy_ready) $display("FAIL stall_ready_low: got 1 exp 0"); else n_pass++;
        n_checks++; if (obs_after_valid !== 1'b0 || obs_after_state !== ST_IDLE)
            $display("FAIL stall_after_handshake: got valid=%0b state=%0d exp 0/%0d", obs_after_valid, obs_after_state, ST_IDLE); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        idle_inputs();
        bus.req1_valid = 1; bus.req1_op = 4'(SLOW); bus.req1_a = $urandom; bus.req1_b = $urandom;
        @(posedge clk); #1;
        bus.req1_valid = 0;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        last_win = 1;
        n_checks++; if (fsm_state !== ST_IDLE || bus.rsp_valid !== 1'b0)
            $display("FAIL midreset_state: got state=%0d valid=%0b exp %0d/0", fsm_state, bus.rsp_valid, ST_IDLE); else n_pass++;
        n_checks++; if (bus.alu_sel !== 4'd0 || bus.alu_a !== '0 || bus.alu_b !== '0)
            $display("FAIL midreset_alu: got sel=%0h a=%0h b=%0h exp 0/0/0", bus.alu_sel, bus.alu_a, bus.alu_b); else n_pass++;
        n_checks++; if (bus.rsp_data !== '0 || bus.rsp_err !== 1'b0 || bus.rsp_id !== 1'b0)
            $display("FAIL midreset_rsp: got data=%0h err=%0b id=%0b exp 0/0/0", bus.rsp_data, bus.rsp_err, bus.rsp_id); else n_pass++;
        seen = 0;
        repeat (8) begin
            if (bus.rsp_valid) seen = 1;
            @(posedge clk); #1;
        end
        n_checks++; if (seen) $display("FAIL midreset_no_rsp: got 1 exp 0"); else n_pass++;
        run_txn(1, 1, 4'd3, 32'hF0F0, 32'h0FF0, 4'd4, 32'h1, 32'h3, 0);
        n_checks++; if (obs_win !== exp_win(1, 1)) $display("FAIL midreset_prio: got %0d exp %0d", obs_win, exp_win(1, 1)); else n_pass++;
        last_win = exp_win(1, 1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            bit v0, v1;
            logic [3:0] op0, op1, op;
            logic [W-1:0] a0, b0, a1, b1;
            int ew, st;
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1;
            op0 = 4'($urandom_range(0, 7)); op1 = 4'($urandom_range(0, 7));
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            st = $urandom_range(0, 2);
            ew = exp_win(v0, v1);
            op = ew ? op1 : op0;
            run_txn(v0, v1, op0, a0, b0, op1, a1, b1, st);
            n_checks++; if (obs_win !== ew || obs_lat !== exp_lat(op))
                $display("FAIL rand_grant_lat_%0d: got win=%0d lat=%0d exp %0d/%0d", k, obs_win, obs_lat, ew, exp_lat(op)); else n_pass++;
            n_checks++; if (obs_id !== 1'(ew) || obs_err !== (int'(op) >= NSEL) ||
                            obs_data !== (ew ? exp_data(op1, a1, b1) : exp_data(op0, a0, b0)))
                $display("FAIL rand_rsp_%0d: got id=%0b err=%0b data=%0h exp %0d/%0b/%0h", k, obs_id, obs_err, obs_data,
                         ew, int'(op) >= NSEL, ew ? exp_data(op1, a1, b1) : exp_data(op0, a0, b0)); else n_pass++;
            n_checks++; if (sel_moved || busy_ready || rsp_moved)
                $display("FAIL rand_stability_%0d: got sel=%0b ready=%0b rsp=%0b exp 0/0/0", k, sel_moved, busy_ready, rsp_moved); else n_pass++;
            last_win = ew;
        end
    endtask

    initial begin
        test_reset();
        test_fast_forced();
        test_slow();
        test_alternate();
        test_illegal();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
